// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin codes, acceptor state encoding
// and the width-window helper used by the classifier.
package vm_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_A    = 2'b01;
  localparam logic [1:0] COIN_B    = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MEASURE,
    ST_CLASSIFY,
    ST_LOCKOUT,
    ST_JAM
  } acc_state_t;

  function automatic logic in_window(input int width, input int lo, input int hi);
    return (width >= lo) && (width <= hi);
  endfunction

endpackage

// File: rtl/coin_acceptor_if.sv
// Acceptor <-> vending machine signals. With COIN_ACCEPTOR_COUNT_EN defined
// the bundle also carries the 16-bit accepted_count.
interface coin_acceptor_if;

  logic       inhibit;
  logic [1:0] coin_out;
  logic       reject;
  logic       jam;
  logic       busy;

`ifdef COIN_ACCEPTOR_COUNT_EN
  logic [15:0] accepted_count;

  modport master (input inhibit, output coin_out, reject, jam, busy, accepted_count);
  modport slave  (output inhibit, input coin_out, reject, jam, busy, accepted_count);
`else
  modport master (input inhibit, output coin_out, reject, jam, busy);
  modport slave  (output inhibit, input coin_out, reject, jam, busy);
`endif

endinterface

// File: rtl/coin_acceptor_sense_debounce.sv
// Two-flop synchroniser plus debouncer for the optical coin sensor; level
// changes after DEB_CYCLES consecutive samples that disagree with it.
module sense_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int DW = $clog2(DEB_CYCLES + 1);

  logic [1:0]    sync;
  logic [DW-1:0] stable_cnt;

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync       <= '0;
      stable_cnt <= '0;
      level      <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync[1] == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == DW'(DEB_CYCLES - 1)) begin
        // Edge pulses coincide with the first cycle of the new level.
        level      <= sync[1];
        rise       <= sync[1];
        fall       <= ~sync[1];
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: measures the debounced sensor pulse width and classifies it
// as coin A, coin B or reject. Optional COIN_ACCEPTOR_COUNT_EN adds a counter.
module coin_acceptor
  import vm_pkg::*;
#(
  parameter int DEB_CYCLES     = 4,
  parameter int A_MIN          = 20,
  parameter int A_MAX          = 40,
  parameter int B_MIN          = 60,
  parameter int B_MAX          = 100,
  parameter int JAM_CYCLES     = 255,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           coin_sense,
  coin_acceptor_if.master bus
);

  logic level, rise, fall;

  sense_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_sense (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (coin_sense),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  acc_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       coin_q;
  logic             reject_q, jam_q, busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      coin_q   <= COIN_NONE;
      reject_q <= 1'b0;
      jam_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      coin_q   <= COIN_NONE;
      reject_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rise) begin
            state  <= ST_MEASURE;
            cnt    <= CNT_W'(1);
            busy_q <= 1'b1;
          end
        end
        ST_MEASURE: begin
          if (cnt == CNT_W'(JAM_CYCLES)) begin
            state <= ST_JAM;
            jam_q <= 1'b1;
          end else if (fall) begin
            // Verdict is registered here so it is visible in the CLASSIFY cycle.
            state <= ST_CLASSIFY;
            if (bus.inhibit)                             reject_q <= 1'b1;
            else if (in_window(32'(cnt), A_MIN, A_MAX)) coin_q   <= COIN_A;
            else if (in_window(32'(cnt), B_MIN, B_MAX)) coin_q   <= COIN_B;
            else                                         reject_q <= 1'b1;
          end else if (level && cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_CLASSIFY: begin
          state <= ST_LOCKOUT;
          cnt   <= CNT_W'(1);
        end
        ST_LOCKOUT: begin
          // Edges seen here are dropped; a coin still present at exit has no rise.
          if (cnt >= CNT_W'(LOCKOUT_CYCLES)) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_JAM: begin
          if (!level) begin
            state <= ST_LOCKOUT;
            jam_q <= 1'b0;
            cnt   <= CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.coin_out = coin_q;
  assign bus.reject   = reject_q;
  assign bus.jam      = jam_q;
  assign bus.busy     = busy_q;

`ifdef COIN_ACCEPTOR_COUNT_EN
  logic [15:0] accepted_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    accepted_q <= '0;
    else if (coin_q != COIN_NONE)  accepted_q <= accepted_q + 16'd1;
  end

  assign bus.accepted_count = accepted_q;
`endif

endmodule
